// File: rtl/fonttoascii_dump_pkg.sv
// fonttoascii_dump_pkg: dump FSM states, character constants and the font-code to ASCII map.
package fonttoascii_dump_pkg;
  typedef enum logic [2:0] {IDLE, RD, LATCH, SPC, CHR, EOL, FIN} state_t;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [5:0] FONT_SP  = 6'h00;
  function automatic logic [7:0] font_to_ascii(input logic [5:0] code);
    return {1'b0, code[5], ~code[5], code[4:0]};
  endfunction
endpackage

// File: rtl/fonttoascii_dump_tx_hold_reg.sv
// fonttoascii_dump_tx_hold_reg: registered valid/ready byte output, held stable while stalled.
module fonttoascii_dump_tx_hold_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fonttoascii_dump.sv
// fonttoascii_dump: dumps the character buffer row by row as ASCII with a 0x0A per row.
// FONTDUMP_TRIM_EN: drop trailing spaces per row, emitting interior space runs lazily.
module fonttoascii_dump
  import fonttoascii_dump_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [5:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  state_t r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic w_hs, w_last_col, w_load, w_adv;
  logic [7:0] w_data;
`ifdef FONTDUMP_TRIM_EN
  logic [CW-1:0] r_space_run;
  logic [5:0] r_cur;
`endif
  assign w_hs = tx_valid & tx_ready;
  assign w_last_col = r_col == COL_LAST;
  always_comb begin
    w_load = 1'b0;
    w_data = ASCII_LF;
    w_adv  = r_state == CHR && w_hs;
    case (r_state)
`ifdef FONTDUMP_TRIM_EN
      LATCH: begin
        w_adv  = rd_data == FONT_SP;
        w_load = rd_data != FONT_SP || w_last_col;
        w_data = rd_data == FONT_SP ? ASCII_LF : r_space_run != '0 ? ASCII_SP : font_to_ascii(rd_data);
      end
      SPC: begin
        w_load = w_hs;
        w_data = r_space_run == CW'(1) ? font_to_ascii(r_cur) : ASCII_SP;
      end
`else
      LATCH: begin
        w_load = 1'b1;
        w_data = font_to_ascii(rd_data);
      end
`endif
      CHR: w_load = w_hs & w_last_col;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      r_col   <= '0;
      r_row   <= '0;
`ifdef FONTDUMP_TRIM_EN
      r_space_run <= '0;
      r_cur       <= '0;
`endif
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= RD;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= '0;
          r_col   <= '0;
          r_row   <= '0;
`ifdef FONTDUMP_TRIM_EN
          r_space_run <= '0;
`endif
        end
        RD: r_state <= LATCH;
`ifdef FONTDUMP_TRIM_EN
        LATCH: begin
          r_cur <= rd_data;
          if (rd_data == FONT_SP) r_space_run <= r_space_run + 1'b1;
          else r_state <= r_space_run != '0 ? SPC : CHR;
        end
        SPC: if (w_hs) begin
          r_space_run <= r_space_run - 1'b1;
          if (r_space_run == CW'(1)) r_state <= CHR;
        end
`else
        LATCH: r_state <= CHR;
`endif
        EOL: if (w_hs) begin
          if (r_row != ROW_LAST) begin
            r_row   <= r_row + 1'b1;
            r_col   <= '0;
            rd_addr <= rd_addr + 1'b1;
            rd_en   <= 1'b1;
            r_state <= RD;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN: r_state <= IDLE;
        default: ;
      endcase
      // Column advance shared by a consumed character and a swallowed space.
      if (w_adv) begin
        if (w_last_col) begin
          r_state <= EOL;
`ifdef FONTDUMP_TRIM_EN
          r_space_run <= '0;
`endif
        end else begin
          r_col   <= r_col + 1'b1;
          rd_addr <= rd_addr + 1'b1;
          rd_en   <= 1'b1;
          r_state <= RD;
        end
      end
    end
  end
  fonttoascii_dump_tx_hold_reg u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_data),
    .i_ready (tx_ready),
    .o_valid (tx_valid),
    .o_data  (tx_data)
  );
endmodule

// File: tb/tb_fonttoascii_dump.sv
// tb_fonttoascii_dump: directed dumps of a 4x2 buffer, expectations chosen by FONTDUMP_TRIM_EN.
module tb_fonttoascii_dump;
  localparam int COLS = 4, ROWS = 2, ADDR_W = 3;
  logic clk = 0, rst = 1, start = 0, tx_ready = 1;
  logic busy, done, rd_en, tx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [5:0] rd_data;
  logic [7:0] tx_data;
  logic [5:0] mem [8];
  logic [7:0] got [$];
  logic [7:0] e1 [$], e2 [$], e3 [$];
  int done_cnt = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  fonttoascii_dump #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );
  // Buffer model: data appears one cycle after the strobe, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 6'h3F;
  always @(negedge clk) begin
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (done) done_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_row(input int r, input logic [5:0] a, b, c, d);
    mem[r*4] = a; mem[r*4+1] = b; mem[r*4+2] = c; mem[r*4+3] = d;
  endtask
  task automatic run_dump(input string tag, input logic [7:0] exp [$], input bit timing, input bit stall);
    int n;
    got.delete();
    done_cnt = 0;
    tx_ready = !stall;
    start = 1;
    step(1);
    start = 0;
    if (timing) begin
      check({tag, "_busy1"}, busy, 1);
      check({tag, "_rden1"}, rd_en, 1);
      check({tag, "_addr1"}, rd_addr, 0);
      step(1);
      check({tag, "_valid2"}, tx_valid, 0);
      step(1);
      check({tag, "_valid3"}, tx_valid, 1);
      check({tag, "_data3"}, tx_data, exp[0]);
    end
    if (stall) begin
      n = 0;
      while (!tx_valid && n < 10) begin step(1); n++; end
      check({tag, "_valid_seen"}, tx_valid, 1);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("%s_hold_valid%0d", tag, i), tx_valid, 1);
        check($sformatf("%s_hold_data%0d", tag, i), tx_data, 8'h48);
        step(1);
      end
      tx_ready = 1;
    end
    n = 0;
    while (done_cnt == 0 && n < 200) begin step(1); n++; end
    check({tag, "_finished"}, n < 200, 1);
    check({tag, "_busy_end"}, busy, 0);
    step(2);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_b%0d", tag, i), i < got.size() ? 32'(got[i]) : 32'hxxxxxxxx, exp[i]);
    check({tag, "_done"}, done_cnt, 1);
  endtask
  initial begin
    int n;
`ifdef FONTDUMP_TRIM_EN
    e1 = '{8'h48, 8'h49, 8'h0A, 8'h31, 8'h0A};
    e2 = '{8'h20, 8'h41, 8'h20, 8'h5F, 8'h0A, 8'h0A};
    e3 = '{8'h0A, 8'h0A};
`else
    e1 = '{8'h48, 8'h49, 8'h20, 8'h20, 8'h0A, 8'h31, 8'h20, 8'h20, 8'h20, 8'h0A};
    e2 = '{8'h20, 8'h41, 8'h20, 8'h5F, 8'h0A, 8'h20, 8'h20, 8'h20, 8'h20, 8'h0A};
    e3 = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h0A, 8'h20, 8'h20, 8'h20, 8'h20, 8'h0A};
`endif
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", rd_en, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    rst = 0;
    step(2);
    set_row(0, 6'h28, 6'h29, 6'h00, 6'h00);
    set_row(1, 6'h11, 6'h00, 6'h00, 6'h00);
    run_dump("basic", e1, 1, 0);
    set_row(0, 6'h00, 6'h21, 6'h00, 6'h3F);
    set_row(1, 6'h00, 6'h00, 6'h00, 6'h00);
    run_dump("inner_sp", e2, 0, 0);
    set_row(0, 6'h00, 6'h00, 6'h00, 6'h00);
    run_dump("blank", e3, 0, 0);
    set_row(0, 6'h28, 6'h29, 6'h00, 6'h00);
    set_row(1, 6'h11, 6'h00, 6'h00, 6'h00);
    run_dump("stall", e1, 0, 1);
    got.delete();
    done_cnt = 0;
    start = 1;
    step(1);
    start = 0;
    n = 0;
    while (got.size() < 2 && n < 50) begin step(1); n++; end
    check("mid_two_bytes", got.size(), 2);
    rst = 1;
    start = 1;
    step(1);
    rst = 0;
    start = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_done", done, 0);
    step(1);
    check("rst_start_ignored", busy, 0);
    step(3);
    check("mid_rst_no_done", done_cnt, 0);
    run_dump("after_rst", e1, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fonttoascii_dump.md
# fonttoascii_dump

Reads the on-screen character buffer, row by row, and turns it back into an ASCII byte stream with one 0x0A per row. It is the read side of the text path: the writer packs ASCII into 6-bit font codes in the buffer, and this block restores ASCII for the debug UART or a host dump. It sits between the character-buffer read port and a byte-stream consumer that uses a valid/ready handshake.

## Interface
- COLS, default 40: characters per row.
- ROWS, default 30: rows in the buffer.
- ADDR_W, default 11: buffer address width; must satisfy 2^ADDR_W ≥ COLS*ROWS.
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  single-cycle pulse that begins a full-screen dump; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the final 0x0A is accepted.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer address, computed as row*COLS+col.
- rd_data  in  6  font code; valid exactly one cycle after rd_en.
- tx_data  out  8  ASCII byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the consumer accepts the byte when both tx_valid and tx_ready are high.

## Operation
- Inverse map: ascii = {1'b0, code[5], ~code[5], code[4:0]}.
  - Codes 0x00–0x1F map to 0x20–0x3F.
  - Codes 0x20–0x3F map to 0x40–0x5F.
  - Code 0x00 is space (0x20).
- FSM states:
  - IDLE: on start go to RD, with address 0 and space_run 0.
  - RD: assert rd_en and rd_addr for one cycle, then go to LATCH.
  - LATCH: register rd_data as cur.
    - If cur is a space and trimming is enabled: increment space_run, then NEXT.
    - Otherwise, if space_run is nonzero go to SPC, else go to CHR.
  - SPC: present 0x20; on each handshake decrement space_run; at zero go to CHR.
  - CHR: present the mapped cur; on handshake go to NEXT.
  - NEXT (zero-cycle decision, folded into the preceding transition):
    - If col < COLS-1: increment col and address, then RD.
    - Otherwise go to EOL.
  - EOL: discard space_run (trailing spaces are dropped) and present 0x0A. On handshake:
    - If row < ROWS-1: set col to 0, increment row, go to RD.
    - Otherwise go to FIN.
  - FIN: pulse done and return to IDLE.
- Counter widths:
  - col and space_run are $clog2(COLS) bits.
  - row is $clog2(ROWS) bits.
  - The address increments by 1 in place of a multiply and never wraps inside a dump.
- start while busy has no effect. start in the same cycle as rst is ignored.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, tx_valid=0, tx_data=0x00. The FSM is in IDLE with col, row and space_run cleared.
- start sampled at cycle 0 gives busy=1 and rd_en=1 at cycle 1, and the first tx_valid at cycle 3 at the earliest.
- Non-space characters need at least 3 cycles each: RD, LATCH, then CHR with ready held high.
- While tx_valid=1 and tx_ready=0, tx_data must stay stable and tx_valid must not drop.
- tx_valid never depends combinationally on tx_ready.
- done coincides with the cycle after the last 0x0A handshake, in the same cycle that busy falls.
- rst asserted mid-dump: the next cycle returns to reset values. Any unaccepted byte is dropped and no done pulse is produced.

## Configuration
- FONTDUMP_TRIM_EN defined: trailing spaces in each row are suppressed and interior space runs are emitted before the next non-space character.
- FONTDUMP_TRIM_EN undefined:
  - Every code is emitted in LATCH→CHR order and the SPC state is never entered.
  - space_run logic is removed.
  - Each row produces exactly COLS+1 bytes.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, RD, LATCH, SPC, CHR, EOL, FIN);
  - the constants ASCII_LF=8'h0A, ASCII_SP=8'h20, FONT_SP=6'h00;
  - the function font_to_ascii(code).
- The byte-output register with its stable-while-stalled logic is one natural sub-module, tx_hold_reg.

## Test plan
Benches use COLS=4, ROWS=2 and tx_ready=1 unless a line says otherwise.
- Trim on; row0={0x28,0x29,0x00,0x00}, row1={0x11,0x00,0x00,0x00} → bytes 0x48,0x49,0x0A,0x31,0x0A, then one done pulse.
- Trim on; row0={0x00,0x21,0x00,0x3F} → 0x20,0x41,0x20,0x5F,0x0A. Leading and interior spaces are kept.
- Trim on; both rows all 0x00 → 0x0A,0x0A, done; no 0x20 is ever emitted.
- Trim off; row0 as in the first line → 0x48,0x49,0x20,0x20,0x0A. Total byte count is 10.
- tx_ready held low for 5 cycles on the first byte → tx_valid stays 1 and tx_data stays 0x48 throughout; the stream continues unchanged after release.
- rst pulsed after 2 bytes → the next cycle shows busy=0 and tx_valid=0, with no done. A new start dumps from address 0 again.
